// File: rtl/button_events_pkg.sv
// Shared constants, state encoding and width helpers for the button event block.
package button_events_pkg;

  localparam int BTN_LONG_PRESS_LEN = 50_000_000;
  localparam int BTN_REPEAT_PERIOD  = 10_000_000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_LONG    = 2'd2
  } btn_state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_timer.sv
// Shared hold counter: free-runs unless cleared, flags the selected terminal count.
module button_timer #(
  parameter int W          = 4,
  parameter int LONG_LEN   = 10,
  parameter int REPEAT_LEN = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic sel_long,
  output logic done
);

  localparam logic [W-1:0] LONG_LIM   = W'(LONG_LEN - 1);
  localparam logic [W-1:0] REPEAT_LIM = W'(REPEAT_LEN - 1);

  logic [W-1:0] cnt;

  // Never reaches past the active limit: the owner clears on done and in IDLE.
  always_ff @(posedge clk) begin
    if (reset)      cnt <= '0;
    else if (clear) cnt <= '0;
    else            cnt <= cnt + W'(1);
  end

  assign done = (cnt == (sel_long ? LONG_LIM : REPEAT_LIM));

endmodule

// File: rtl/button_events.sv
// Turns a debounced button level into press/release/long-press/auto-repeat pulses.
// The release event is named release_pulse because "release" is a reserved word.
module button_events
  import button_events_pkg::*;
#(
  parameter int LONG_PRESS_LEN = BTN_LONG_PRESS_LEN,
  parameter int REPEAT_PERIOD  = BTN_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic reset,
  input  logic in,
  input  logic repeat_en,
  output logic press,
  output logic release_pulse,
  output logic long_press,
  output logic repeat_pulse,
  output logic held
);

  localparam int CNT_W = clog2(max_int(LONG_PRESS_LEN, REPEAT_PERIOD));

  btn_state_t state;
  logic       done;
  logic       clear;
  logic       sel_long;

  assign clear    = (state == ST_IDLE) || done;
  assign sel_long = (state == ST_PRESSED);

  button_timer #(
    .W          (CNT_W),
    .LONG_LEN   (LONG_PRESS_LEN),
    .REPEAT_LEN (REPEAT_PERIOD)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .sel_long (sel_long),
    .done     (done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      press         <= 1'b0;
      release_pulse <= 1'b0;
      long_press    <= 1'b0;
      repeat_pulse  <= 1'b0;
      held          <= 1'b0;
    end else begin
      press         <= 1'b0;
      release_pulse <= 1'b0;
      long_press    <= 1'b0;
      repeat_pulse  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (in) begin
            press <= 1'b1;
            held  <= 1'b1;
            state <= ST_PRESSED;
          end
        end
        ST_PRESSED: begin
          if (!in) begin
            release_pulse <= 1'b1;
            held          <= 1'b0;
            state         <= ST_IDLE;
          end else if (done) begin
            long_press <= 1'b1;
            state      <= ST_LONG;
          end
        end
        ST_LONG: begin
          // Counter keeps running with repeat_en low so the repeat phase never shifts.
          if (!in) begin
            release_pulse <= 1'b1;
            held          <= 1'b0;
            state         <= ST_IDLE;
          end else if (done) begin
            repeat_pulse <= repeat_en;
          end
        end
        default: begin
          held  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_events.sv
// Self-checking bench for button_events: vector table, hand sequences, random vs model.
module tb_button_events;

  localparam int L = 10;
  localparam int R = 4;

  logic clk = 1'b0;
  logic reset, in, repeat_en;
  logic press, release_pulse, long_press, repeat_pulse, held;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  button_events #(.LONG_PRESS_LEN(L), .REPEAT_PERIOD(R)) dut (
    .clk           (clk),
    .reset         (reset),
    .in            (in),
    .repeat_en     (repeat_en),
    .press         (press),
    .release_pulse (release_pulse),
    .long_press    (long_press),
    .repeat_pulse  (repeat_pulse),
    .held          (held)
  );

  // Output vector order: {press, release, long_press, repeat_pulse, held}
  typedef struct packed {
    logic       in_v;
    logic       en;
    logic       rst;
    logic [4:0] exp;
  } vec_t;

  vec_t tbl[$];

  // Reference model: tracks whether the button is held and how many cycles since press.
  bit         m_held = 1'b0;
  int         m_age  = 0;
  logic [4:0] m_exp  = '0;

  function automatic logic [4:0] outs();
    return {press, release_pulse, long_press, repeat_pulse, held};
  endfunction

  function automatic vec_t mk(input logic i, input logic e, input logic r, input logic [4:0] x);
    vec_t v;
    v.in_v = i; v.en = e; v.rst = r; v.exp = x;
    return v;
  endfunction

  task automatic check_vec(input string name, input logic [4:0] got, input logic [4:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b expected %b (press,rel,long,rep,held)", name, $time, got, exp);
    end
  endtask

  task automatic model_step(input logic i, input logic e, input logic r);
    m_exp = '0;
    if (r) begin
      m_held = 1'b0;
      m_age  = 0;
    end else if (!m_held) begin
      if (i) begin
        m_held   = 1'b1;
        m_age    = 0;
        m_exp[4] = 1'b1;
      end
    end else if (!i) begin
      m_held   = 1'b0;
      m_exp[3] = 1'b1;
    end else begin
      m_age++;
      if (m_age == L) m_exp[2] = 1'b1;
      else if (m_age > L && ((m_age - L) % R) == 0) m_exp[1] = e;
    end
    m_exp[0] = m_held;
  endtask

  task automatic step(input logic i, input logic e, input logic r);
    in = i; repeat_en = e; reset = r;
    @(posedge clk);
    model_step(i, e, r);
    @(negedge clk);
    check_vec("model", outs(), m_exp);
  endtask

  initial begin
    logic cur_in, cur_en, cur_rst;
    logic long_seen, rep_seen;

    in = 1'b0; repeat_en = 1'b0; reset = 1'b1;

    // Short press
    tbl.push_back(mk(0, 0, 1, 5'b00000));
    for (int k = 0; k < 4; k++) tbl.push_back(mk(0, 0, 0, 5'b00000));
    tbl.push_back(mk(1, 0, 0, 5'b10001));
    for (int k = 0; k < 4; k++) tbl.push_back(mk(1, 0, 0, 5'b00001));
    tbl.push_back(mk(0, 0, 0, 5'b01000));
    tbl.push_back(mk(0, 0, 0, 5'b00000));
    // Long hold with repeat: 20 samples high then release
    for (int s = 1; s <= 20; s++) begin
      if (s == 1)                 tbl.push_back(mk(1, 1, 0, 5'b10001));
      else if (s == 11)           tbl.push_back(mk(1, 1, 0, 5'b00101));
      else if (s == 15 || s == 19) tbl.push_back(mk(1, 1, 0, 5'b00011));
      else                        tbl.push_back(mk(1, 1, 0, 5'b00001));
    end
    tbl.push_back(mk(0, 1, 0, 5'b01000));
    tbl.push_back(mk(0, 0, 0, 5'b00000));

    @(negedge clk);
    foreach (tbl[n]) begin
      step(tbl[n].in_v, tbl[n].en, tbl[n].rst);
      check_vec($sformatf("table[%0d]", n), outs(), tbl[n].exp);
    end

    // Release on the cycle the long-press timer would expire
    long_seen = 1'b0;
    for (int s = 1; s <= 10; s++) begin
      step(1, 0, 0);
      long_seen |= long_press;
    end
    step(0, 0, 0);
    long_seen |= long_press;
    check_vec("expiry_release", outs(), 5'b01000);
    check_vec("expiry_no_long", {4'b0, long_seen}, 5'b00000);
    step(0, 0, 0);

    // Repeat disabled
    rep_seen = 1'b0;
    for (int s = 1; s <= 20; s++) begin
      step(1, 0, 0);
      rep_seen |= repeat_pulse;
      if (s == 11) check_vec("norep_long", outs(), 5'b00101);
    end
    check_vec("norep_none", {4'b0, rep_seen}, 5'b00000);
    step(0, 0, 0);
    step(0, 0, 0);

    // Enable raised mid-hold keeps repeat phase
    for (int s = 1; s <= 24; s++) begin
      step(1, (s >= 16) ? 1'b1 : 1'b0, 0);
      if (s == 15) check_vec("toggle_off15", outs(), 5'b00001);
      if (s == 19) check_vec("toggle_rep19", outs(), 5'b00011);
      if (s == 23) check_vec("toggle_rep23", outs(), 5'b00011);
    end
    step(0, 0, 0);

    // Reset mid-LONG with the button still down
    for (int s = 1; s <= 14; s++) step(1, 1, 0);
    step(1, 1, 1);
    check_vec("rst_abort", outs(), 5'b00000);
    step(1, 1, 0);
    check_vec("press_after_rst", outs(), 5'b10001);
    step(0, 1, 0);
    check_vec("release_after_rst", outs(), 5'b01000);

    // Randomized run against the model
    cur_in = 1'b0; cur_en = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 13) == 0) cur_in = ~cur_in;
      if ($urandom_range(0, 29) == 0) cur_en = ~cur_en;
      cur_rst = ($urandom_range(0, 299) == 0);
      step(cur_in, cur_en, cur_rst);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
